// File: rtl/bp_nonsynth_dma_initiator.sv
// bp_nonsynth_dma_initiator: single-outstanding line request -> bsg_cache DMA
// packet plus a dma_burst_len_p-beat data burst. Read bursts are assembled
// into a full line and write lines are serialized into beats.
// Optional macro BP_DMA_INITIATOR_WATCHDOG_EN builds a stall watchdog that
// drives a sticky error_o; without it error_o is tied low.
module bp_nonsynth_dma_initiator #(
  parameter int dma_addr_width_p  = 28,
  parameter int dma_data_width_p  = 64,
  parameter int dma_burst_len_p   = 8,
  parameter int dma_mask_width_p  = 1,
  parameter int watchdog_cycles_p = 4096,
  localparam int LINE_W = dma_data_width_p * dma_burst_len_p,
  localparam int PKT_W  = 1 + dma_addr_width_p + dma_mask_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        req_v_i,
  output logic                        req_ready_and_o,
  input  logic                        req_write_i,
  input  logic [dma_addr_width_p-1:0] req_addr_i,
  input  logic [LINE_W-1:0]           req_data_i,
  output logic                        resp_v_o,
  input  logic                        resp_ready_and_i,
  output logic                        resp_write_o,
  output logic [dma_addr_width_p-1:0] resp_addr_o,
  output logic [LINE_W-1:0]           resp_data_o,
  output logic [PKT_W-1:0]            dma_pkt_o,
  output logic                        dma_pkt_v_o,
  input  logic                        dma_pkt_yumi_i,
  input  logic [dma_data_width_p-1:0] dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_ready_and_o,
  output logic [dma_data_width_p-1:0] dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_yumi_i,
  output logic                        error_o
);

  localparam int LINE_OFF = $clog2(dma_data_width_p / 8) + $clog2(dma_burst_len_p);
  localparam int CNT_W    = (dma_burst_len_p > 1) ? $clog2(dma_burst_len_p) : 1;
  localparam logic [dma_addr_width_p-1:0] ADDR_MASK =
    ~(dma_addr_width_p'((64'd1 << LINE_OFF) - 64'd1));

  typedef enum logic [1:0] {e_ready, e_read, e_write, e_resp} state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        pkt_sent_q, pkt_sent_d;
  logic                        data_done_q, data_done_d;
  logic                        write_q, write_d;
  logic [dma_addr_width_p-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]           line_q, line_d;

  logic             last_beat;
  logic [CNT_W-1:0] cnt_next;
  logic             pkt_now;

  // beat counter wraps on the last beat; a one-beat burst pins it at 0
  assign last_beat = (cnt_q == CNT_W'(dma_burst_len_p - 1));
  assign cnt_next  = (dma_burst_len_p == 1 || last_beat) ? '0 : cnt_q + 1'b1;
  assign pkt_now   = pkt_sent_q | dma_pkt_yumi_i;

  assign dma_pkt_o    = {write_q, addr_q, {dma_mask_width_p{1'b1}}};
  assign dma_data_o   = line_q[cnt_q*dma_data_width_p +: dma_data_width_p];
  assign resp_write_o = write_q;
  assign resp_addr_o  = addr_q;
  assign resp_data_o  = write_q ? '0 : line_q;

  // next-state and handshake outputs; all valids/ready forced low in reset
  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    pkt_sent_d           = pkt_sent_q;
    data_done_d          = data_done_q;
    write_d              = write_q;
    addr_d               = addr_q;
    line_d               = line_q;
    req_ready_and_o      = 1'b0;
    resp_v_o             = 1'b0;
    dma_pkt_v_o          = 1'b0;
    dma_data_ready_and_o = 1'b0;
    dma_data_v_o         = 1'b0;
    case (state_q)
      e_ready: begin
        req_ready_and_o = 1'b1;
        if (req_v_i) begin
          write_d     = req_write_i;
          addr_d      = req_addr_i & ADDR_MASK;
          line_d      = req_write_i ? req_data_i : '0;
          cnt_d       = '0;
          pkt_sent_d  = 1'b0;
          data_done_d = 1'b0;
          state_d     = req_write_i ? e_write : e_read;
        end
      end
      e_read: begin
        dma_pkt_v_o          = !pkt_sent_q;
        dma_data_ready_and_o = 1'b1;
        if (dma_pkt_yumi_i) pkt_sent_d = 1'b1;
        // beats past the end of the line are accepted but dropped
        if (dma_data_v_i && !data_done_q) begin
          line_d[cnt_q*dma_data_width_p +: dma_data_width_p] = dma_data_i;
          cnt_d = cnt_next;
          if (last_beat) data_done_d = 1'b1;
        end
        if (pkt_now && (data_done_q || (dma_data_v_i && last_beat))) state_d = e_resp;
      end
      e_write: begin
        dma_pkt_v_o  = !pkt_sent_q;
        dma_data_v_o = !data_done_q;
        if (dma_pkt_yumi_i) pkt_sent_d = 1'b1;
        if (dma_data_yumi_i && !data_done_q) begin
          cnt_d = cnt_next;
          if (last_beat) data_done_d = 1'b1;
        end
        if (pkt_now && (data_done_q || (dma_data_yumi_i && last_beat))) state_d = e_resp;
      end
      e_resp: begin
        resp_v_o = 1'b1;
        if (resp_ready_and_i) begin
          cnt_d       = '0;
          pkt_sent_d  = 1'b0;
          data_done_d = 1'b0;
          state_d     = e_ready;
        end
      end
      default: state_d = e_ready;
    endcase
    if (!reset_n_i) begin
      req_ready_and_o      = 1'b0;
      resp_v_o             = 1'b0;
      dma_pkt_v_o          = 1'b0;
      dma_data_ready_and_o = 1'b0;
      dma_data_v_o         = 1'b0;
    end
  end

  // state register; reset discards any in-flight line silently
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= e_ready;
      cnt_q       <= '0;
      pkt_sent_q  <= 1'b0;
      data_done_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pkt_sent_q  <= pkt_sent_d;
      data_done_q <= data_done_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      line_q      <= line_d;
    end
  end

`ifdef BP_DMA_INITIATOR_WATCHDOG_EN
  localparam int WD_W = $clog2(watchdog_cycles_p + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            dma_hs;

  assign dma_hs = (dma_pkt_v_o & dma_pkt_yumi_i)
                | (dma_data_ready_and_o & dma_data_v_i)
                | (dma_data_v_o & dma_data_yumi_i);
  assign error_o = err_q;

  // idle-cycle counter: cleared by any DMA progress or when idle
  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (state_q == e_ready || dma_hs) wd_d = '0;
    else if (wd_q != WD_W'(watchdog_cycles_p)) wd_d = wd_q + 1'b1;
    if (wd_d == WD_W'(watchdog_cycles_p)) err_d = 1'b1;
  end

  // sticky error; the message fires only on the rising transition
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
      if (err_d && !err_q) $error("bp_nonsynth_dma_initiator: DMA watchdog expired");
    end
  end
`else
  assign error_o = 1'b0;
`endif

endmodule
